// File: rtl/secure_frv_mask_share_encoder_if.sv
//==============================================================================
// Module      : secure_frv_mask_share_encoder_if
// Description : Operand/share handshake bundle for the masked FRV share
//               encoder. The reseed channel exists only when the macro
//               SECURE_FRV_MASK_RESEED_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface secure_frv_mask_share_encoder_if #(
  parameter int N = 32
);
  // Operand offer
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  // Share / randomness delivery
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ax;
  logic [N-1:0] ay;
  logic [N-1:0] bx;
  logic [N-1:0] by;
  logic [N-1:0] z0;
  logic [N-1:0] z1;
`ifdef SECURE_FRV_MASK_RESEED_EN
  // Reseed channel
  logic         seed_valid;
  logic         seed_ready;
  logic [31:0]  seed;
`endif

  // Environment side: offers operands, consumes shares
  modport master (
    output in_valid, rs1, rs2, out_ready,
`ifdef SECURE_FRV_MASK_RESEED_EN
    output seed_valid, seed,
    input  seed_ready,
`endif
    input  in_ready, out_valid, ax, ay, bx, by, z0, z1
  );

  // Encoder side
  modport slave (
    input  in_valid, rs1, rs2, out_ready,
`ifdef SECURE_FRV_MASK_RESEED_EN
    input  seed_valid, seed,
    output seed_ready,
`endif
    output in_ready, out_valid, ax, ay, bx, by, z0, z1
  );
endinterface

`default_nettype wire

// File: rtl/secure_frv_mask_share_encoder.sv
//==============================================================================
// Module      : secure_frv_mask_share_encoder
// Description : Splits unmasked operands rs1/rs2 into two Boolean shares and
//               supplies fresh randomness z0/z1 for the downstream two-share
//               masked AND gadget. A 32-bit Galois LFSR is harvested on four
//               consecutive enabled cycles (mx, my, z0, z1) per operation.
//               Optional reseed port: define SECURE_FRV_MASK_RESEED_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module secure_frv_mask_share_encoder #(
  parameter int          N    = 32,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  wire logic g_clk,
  input  wire logic g_reset,
  input  wire logic clk_en,
  secure_frv_mask_share_encoder_if.slave bus
);

  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   phase;
  logic [31:0]  lfsr;
  logic [31:0]  lfsr_next;
  logic [N-1:0] harvest;

  logic [N-1:0] rs1_q;
  logic [N-1:0] rs2_q;
  logic [N-1:0] mx;
  logic [N-1:0] my;
  logic [N-1:0] z0_q;

  logic         out_valid;
  logic [N-1:0] ax;
  logic [N-1:0] ay;
  logic [N-1:0] bx;
  logic [N-1:0] by;
  logic [N-1:0] z0;
  logic [N-1:0] z1;

  logic         accept;
  logic         seed_load;
  logic         in_ready;
  logic [31:0]  seed_value;

  // Galois right-shift step; the harvest is the pre-step value
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0000_0000);
  assign harvest   = lfsr[N-1:0];

`ifdef SECURE_FRV_MASK_RESEED_EN
  // A zero seed would lock the LFSR, so fall back to the reset seed
  assign seed_value     = (bus.seed == 32'h0000_0000) ? SEED : bus.seed;
  assign bus.seed_ready = (state == S_IDLE);
`else
  assign seed_value = SEED;
`endif

  // Next-state and handshake decode; seed load wins over operand accept
  always_comb begin
    state_next = state;
    seed_load  = 1'b0;
    accept     = 1'b0;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef SECURE_FRV_MASK_RESEED_EN
        seed_load = bus.seed_valid & clk_en;
`endif
        in_ready = ~seed_load;
        accept   = bus.in_valid & in_ready & clk_en;
        if (accept) begin
          state_next = S_GEN;
        end
      end
      S_GEN: begin
        if (clk_en && (phase == 2'd3)) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (clk_en && out_valid && bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LFSR, harvest latches and share output registers; all frozen when clk_en is low
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lfsr      <= SEED;
      phase     <= 2'd0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      mx        <= '0;
      my        <= '0;
      z0_q      <= '0;
      out_valid <= 1'b0;
      ax        <= '0;
      ay        <= '0;
      bx        <= '0;
      by        <= '0;
      z0        <= '0;
      z1        <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (seed_load) begin
            lfsr <= seed_value;
          end else if (accept) begin
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            phase <= 2'd0;
          end
        end
        S_GEN: begin
          lfsr  <= lfsr_next;
          phase <= phase + 2'd1;
          case (phase)
            2'd0: mx   <= harvest;
            2'd1: my   <= harvest;
            2'd2: z0_q <= harvest;
            default: begin
              // Final harvest: publish the complete share set at once
              z1        <= harvest;
              z0        <= z0_q;
              ax        <= rs1_q ^ mx;
              bx        <= mx;
              ay        <= rs2_q ^ my;
              by        <= my;
              out_valid <= 1'b1;
            end
          endcase
        end
        S_OUT: begin
          if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ax        = ax;
  assign bus.ay        = ay;
  assign bus.bx        = bx;
  assign bus.by        = by;
  assign bus.z0        = z0;
  assign bus.z1        = z1;

endmodule

`default_nettype wire
